alu_seq: RTL

Parametrised, multi-cycle successor to the single-cycle RV32I ALU. Executes all base integer ALU functions in one cycle and adds the RV32M multiply/divide/remainder group through an iterative shared datapath with a START/BUSY/DONE handshake. Sits in the execute stage; the control FSM stalls on BUSY and captures ALU_OUT on DONE.

---
 rtl/alu_seq.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// RV32I ALU with an iterative RV32M multiply/divide unit and a START/BUSY/DONE handshake.
// Define ALU_MULDIV_EN to build the M-extension datapath; otherwise every M code returns 0 in one cycle.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [4:0]       ALU_FUN,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] ALU_OUT
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             accept;

  assign BUSY    = (state_q == S_MUL) || (state_q == S_DIV);
  assign DONE    = (state_q == S_FIN);
  assign ALU_OUT = out_q;
  // FIN is not busy, so a new request is taken in the DONE cycle without a bubble.
  assign accept  = START && !BUSY;

  function automatic logic [WIDTH-1:0] base_alu(input logic [3:0]       fun,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    logic [SHW-1:0]   sh;
    sh = b[SHW-1:0];
    case (fun)
      4'b0000: r = a + b;
      4'b1000: r = a - b;
      4'b0110: r = a | b;
      4'b0111: r = a & b;
      4'b0100: r = a ^ b;
      4'b0101: r = a >> sh;
      4'b0001: r = a << sh;
      4'b1101: r = $unsigned($signed(a) >>> sh);
      4'b0010: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b0011: r = {{(WIDTH-1){1'b0}}, (a < b)};
      4'b1001: r = a;
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef ALU_MULDIV_EN
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  // acc holds {hi, lo} of the product, or {remainder, quotient} while dividing.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opn_q, opn_d;
  logic [1:0]         mop_q, mop_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  logic               is_div, sgn_a, sgn_b, neg_a, neg_b, div_special;
  logic [WIDTH-1:0]   mag_a, mag_b, special_res;

  assign is_div = ALU_FUN[2];
  assign sgn_a  = is_div ? !ALU_FUN[0] : (ALU_FUN[1:0] != 2'b11);
  assign sgn_b  = is_div ? !ALU_FUN[0] : !ALU_FUN[1];
  assign neg_a  = sgn_a && A[WIDTH-1];
  assign neg_b  = sgn_b && B[WIDTH-1];
  assign mag_a  = neg_a ? -A : A;
  assign mag_b  = neg_b ? -B : B;

  assign div_special = is_div &&
                       ((B == '0) || (!ALU_FUN[0] && (A == MIN_VAL) && (B == '1)));
  assign special_res = (B == '0) ? (ALU_FUN[1] ? A : '1)
                                 : (ALU_FUN[1] ? '0 : MIN_VAL);

  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, mul_prod;
  logic [WIDTH-1:0]   mul_res, div_res, quo, rem;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opn_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opn_q};
    // A borrow out of the trial subtraction means the divisor did not fit: restore.
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
    mul_prod  = (sa_q ^ sb_q) ? -mul_next : mul_next;
    mul_res   = (mop_q == 2'b00) ? mul_prod[WIDTH-1:0] : mul_prod[2*WIDTH-1:WIDTH];
    quo       = div_next[WIDTH-1:0];
    rem       = div_next[2*WIDTH-1:WIDTH];
    div_res   = mop_q[1] ? (sa_q ? -rem : rem) : ((sa_q ^ sb_q) ? -quo : quo);
  end
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
`ifdef ALU_MULDIV_EN
    acc_d   = acc_q;
    opn_d   = opn_q;
    mop_d   = mop_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
`endif
    if (BUSY) begin
`ifdef ALU_MULDIV_EN
      cnt_d = cnt_q + 1'b1;
      acc_d = (state_q == S_MUL) ? mul_next : div_next;
      if (&cnt_q) begin
        state_d = S_FIN;
        out_d   = (state_q == S_MUL) ? mul_res : div_res;
      end
`endif
    end else if (accept) begin
      state_d = S_FIN;
      if (!ALU_FUN[4]) begin
        out_d = base_alu(ALU_FUN[3:0], A, B);
      end else begin
`ifdef ALU_MULDIV_EN
        if (div_special) begin
          out_d = special_res;
        end else begin
          state_d = is_div ? S_DIV : S_MUL;
          acc_d   = {{WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
          opn_d   = is_div ? mag_b : mag_a;
          mop_d   = ALU_FUN[1:0];
          sa_d    = neg_a;
          sb_d    = neg_b;
          cnt_d   = '0;
        end
`else
        out_d = '0;
`endif
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      out_q   <= '0;
`ifdef ALU_MULDIV_EN
      acc_q   <= '0;
      opn_q   <= '0;
      mop_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
`ifdef ALU_MULDIV_EN
      acc_q   <= acc_d;
      opn_q   <= opn_d;
      mop_q   <= mop_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule
